// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial add/subtract controller.
// FSM state encoding and operation mode constants.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bit_addsub_cell.sv
// One-bit full adder / full subtractor selected by mode.
// Purely combinational; the controller owns the carry/borrow flop.
module bit_addsub_cell
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic y,
    output logic cout
);

    logic w_x;

    assign w_x = a ^ b;
    assign y   = w_x ^ cin;

    always_comb begin
        if (mode == MODE_SUB) begin
            cout = (~a & b) | (cin & ~w_x);
        end else begin
            cout = (a & b) | (cin & w_x);
        end
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: LSB-first, one cell step per clock.
// Result, carry/borrow and signed overflow are registered on DONE entry.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic             r_c;
    logic             w_y;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    bit_addsub_cell u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_c),
        .mode (r_mode),
        .y    (w_y),
        .cout (w_co)
    );

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_nxt = {w_y, r_acc[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mode   <= MODE_ADD;
            r_c      <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_mode <= mode;
                        r_c    <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_c   <= w_co;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    // r_c still holds the carry/borrow into the MSB here
                    if (w_last) begin
                        r_result <= w_acc_nxt;
                        r_cout   <= w_co;
                        r_ovf    <= r_c ^ w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (r_state == IDLE);
    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8) and its cell.
// Directed and random operations against an arithmetic reference model.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    logic tc_a, tc_b, tc_cin, tc_mode, tc_y, tc_co;

    int checks   = 0;
    int failures = 0;
    logic [9:0] prev = '0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    bit_addsub_cell u_cell (
        .a    (tc_a),
        .b    (tc_b),
        .cin  (tc_cin),
        .mode (tc_mode),
        .y    (tc_y),
        .cout (tc_co)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, result} from plain integer arithmetic
    function automatic logic [9:0] ref_op(input logic m, input logic [7:0] x,
                                          input logic [7:0] y);
        int s;
        logic [7:0] r;
        logic c, v;
        if (m) begin
            s = int'(x) - int'(y);
            r = s[7:0];
            c = (x < y);
            v = (x[7] != y[7]) && (r[7] != x[7]);
        end else begin
            s = int'(x) + int'(y);
            r = s[7:0];
            c = (s > 255);
            v = (x[7] == y[7]) && (r[7] != x[7]);
        end
        return {v, c, r};
    endfunction

    task automatic wait_done(input int inj, output int lat, output int bz);
        lat = 0;
        bz  = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = (c == inj);
            if (c == inj) begin
                a    = 8'($urandom);
                b    = 8'($urandom);
                mode = 1'($urandom);
            end
            if (c == 1) check("hold", {22'd0, ovf, cout, result}, {22'd0, prev});
            if (busy) bz++;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    // Called at a negedge while ready; leaves at a negedge with ready.
    task automatic op(input string tag, input logic m, input logic [7:0] x,
                      input logic [7:0] y, input int inj, input bit predriven,
                      input bit b2b, input logic nm, input logic [7:0] nx,
                      input logic [7:0] ny);
        int lat, bz;
        logic [9:0] exp;
        exp = ref_op(m, x, y);
        if (!predriven) begin
            start = 1'b1;
            mode  = m;
            a     = x;
            b     = y;
        end
        wait_done(inj, lat, bz);
        check({tag, "_lat"}, lat, 9);
        check({tag, "_busy"}, bz, 8);
        check({tag, "_res"}, {22'd0, ovf, cout, result}, {22'd0, exp});
        prev = exp;
        if (b2b) begin
            start = 1'b1;
            mode  = nm;
            a     = nx;
            b     = ny;
        end
        @(negedge clk);
        check({tag, "_done1"}, done, 0);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int dcnt;
        logic m;
        logic [7:0] x, y;

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;

        for (int i = 0; i < 16; i++) begin
            int v;
            logic [3:0] iv;
            iv      = 4'(i);
            tc_a    = iv[0];
            tc_b    = iv[1];
            tc_cin  = iv[2];
            tc_mode = iv[3];
            #1;
            if (tc_mode)
                v = int'(tc_a) - int'(tc_b) - int'(tc_cin);
            else
                v = int'(tc_a) + int'(tc_b) + int'(tc_cin);
            check($sformatf("cell%0d", i), {30'd0, tc_co, tc_y},
                  {30'd0, (tc_mode ? (v < 0) : (v > 1)), v[0]});
        end

        repeat (3) @(negedge clk);
        check("rst_out", {22'd0, ovf, cout, result}, 32'd0);
        check("rst_hs", {29'd0, ready, busy, done}, 32'b100);
        rst = 1'b0;
        @(negedge clk);

        op("sub53", 1'b1, 8'h05, 8'h03, 0, 0, 0, 0, 0, 0);
        op("sub35", 1'b1, 8'h03, 8'h05, 0, 0, 0, 0, 0, 0);
        op("sub80", 1'b1, 8'h80, 8'h01, 0, 0, 0, 0, 0, 0);
        op("addff", 1'b0, 8'hFF, 8'h01, 0, 0, 0, 0, 0, 0);
        op("add7f", 1'b0, 8'h7F, 8'h01, 0, 0, 0, 0, 0, 0);

        op("ignore", 1'b0, 8'h21, 8'h42, 3, 0, 0, 0, 0, 0);

        op("b2b_a", 1'b0, 8'h10, 8'h20, 0, 0, 1, 1'b1, 8'h11, 8'h99);
        op("b2b_b", 1'b1, 8'h11, 8'h99, 0, 1, 0, 0, 0, 0);

        start = 1'b1;
        mode  = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_out", {22'd0, ovf, cout, result}, 32'd0);
        check("mrst_hs", {29'd0, ready, busy, done}, 32'b100);
        prev = '0;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("mrst_nodone", dcnt, 0);
        op("fresh", 1'b0, 8'h12, 8'h34, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            m = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            op($sformatf("rnd%0d", i), m, x, y, 0, 0, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
